jpeg_dequant_stream: RTL

- Streaming successor to the flat 64-lane combinational dequantiser; processes one coefficient per clock.
- Holds NUM_TABLES programmable quantisation tables, loaded through a dedicated write port.
- Per block, selects one table per 8x8 block, multiplies each row-major coefficient by its table entry, and emits results with valid/ready flow control.
- Sits between inverse zigzag and IDCT. Block boundaries come from an internal 0..63 coefficient counter.

---
 rtl/jpeg_dequant_stream.sv | 125 ++++++++++++
 1 files changed

// File: rtl/jpeg_dequant_stream.sv
// Streaming JPEG dequantiser: one coefficient per clock, NUM_TABLES quant tables,
// two-stage pipeline. Define JPEG_DEQUANT_SAT_EN to saturate outputs instead of wrapping.
module jpeg_dequant_stream #(
  parameter int WIDTH_IN   = 16,
  parameter int WIDTH_Q    = 16,
  parameter int WIDTH_OUT  = 16,
  parameter int NUM_TABLES = 4,
  parameter int TBL_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        q_wr_en,
  input  logic [TBL_W-1:0]            q_wr_tbl,
  input  logic [5:0]                  q_wr_idx,
  input  logic [WIDTH_Q-1:0]          q_wr_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [WIDTH_IN-1:0]  s_data,
  input  logic [TBL_W-1:0]            s_tbl_sel,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [WIDTH_OUT-1:0] m_data,
  output logic                        m_last,
  output logic [5:0]                  m_idx,
  output logic                        sat_flag
);

  localparam logic [TBL_W:0] NT = NUM_TABLES[TBL_W:0];

  logic                       advance;
  logic                       accept;
  logic [5:0]                 cnt;
  logic [TBL_W-1:0]           blk_tbl;
  logic [TBL_W-1:0]           sel_map;
  logic [TBL_W-1:0]           rd_tbl;
  logic [WIDTH_Q-1:0]         qtab [NUM_TABLES][64];

  logic                       s1_valid;
  logic signed [WIDTH_IN-1:0] s1_data;
  logic [5:0]                 s1_idx;
  logic [WIDTH_Q-1:0]         s1_q;

  logic [WIDTH_OUT-1:0]       res;
  logic                       clamp;

  // Whole pipeline moves together; the output register is the only stall point.
  assign advance = !m_valid || m_ready;
  assign s_ready = advance;
  assign accept  = s_valid && advance;

  assign sel_map = ({1'b0, s_tbl_sel} < NT) ? s_tbl_sel : '0;
  assign rd_tbl  = (cnt == 6'd0) ? sel_map : blk_tbl;

  always_ff @(posedge clk) begin
    if (q_wr_en && ({1'b0, q_wr_tbl} < NT)) begin
      qtab[q_wr_tbl][q_wr_idx] <= q_wr_data;
    end
  end

`ifdef JPEG_DEQUANT_SAT_EN
  localparam int PW = WIDTH_IN + WIDTH_Q + 1;

  logic signed [PW-1:0] prod;
  logic                 ovf_hi;
  logic                 ovf_lo;

  assign prod   = $signed(PW'($signed(s1_data))) * $signed(PW'({1'b0, s1_q}));
  assign ovf_hi = !prod[PW-1] && (|prod[PW-2:WIDTH_OUT-1]);
  assign ovf_lo = prod[PW-1] && !(&prod[PW-2:WIDTH_OUT-1]);
  assign clamp  = ovf_hi || ovf_lo;
  assign res    = ovf_hi ? {1'b0, {(WIDTH_OUT-1){1'b1}}} :
                  ovf_lo ? {1'b1, {(WIDTH_OUT-1){1'b0}}} :
                           prod[WIDTH_OUT-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (advance && s1_valid && clamp) begin
      sat_flag <= 1'b1;
    end
  end
`else
  // Low bits of a two's-complement product only depend on the low bits of its operands.
  assign res      = WIDTH_OUT'($signed(s1_data)) * WIDTH_OUT'(s1_q);
  assign clamp    = 1'b0;
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      blk_tbl  <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_idx   <= '0;
      s1_q     <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_idx    <= '0;
      m_data   <= '0;
    end else begin
      if (accept) begin
        cnt <= cnt + 6'd1;
        if (cnt == 6'd0) begin
          blk_tbl <= sel_map;
        end
      end
      if (advance) begin
        s1_valid <= s_valid;
        if (s_valid) begin
          s1_data <= s_data;
          s1_idx  <= cnt;
          s1_q    <= qtab[rd_tbl][cnt];
        end
        m_valid <= s1_valid;
        m_last  <= s1_valid && (s1_idx == 6'd63);
        if (s1_valid) begin
          m_data <= res;
          m_idx  <= s1_idx;
        end
      end
    end
  end

endmodule
